jt10_snd_out: RTL and testbench
===============================

// Module: jt10_snd_out
// PURPOSE
//  Output stage directly downstream of the YM2610 stereo accumulator.
//  Captures each finished left/right sample at the frame boundary.
//  Applies master volume with a bit-serial multiplier and saturates to 16 bits.
//  Buffers the result in a small FIFO drained by a valid/ready sink
//  (resampler, I2S serialiser or DAC bridge).
// PARAMETERS
//  DEPTH  4  FIFO entries; power of two, >=2
//  AW     2  FIFO address width; must equal log2(DEPTH)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   asynchronous reset, active-high
//  clk_en     in   1   chip clock enable (same as accumulator)
//  zero       in   1   frame-boundary strobe from operator scheduler
//  left       in   16  signed accumulated left sample
//  right      in   16  signed accumulated right sample
//  vol        in   8   unsigned master volume, Q1.7 (0x80 = x1.0, 0xFF = x1.992)
//  out_l      out  16  signed FIFO head, left
//  out_r      out  16  signed FIFO head, right
//  out_valid  out  1   FIFO head valid
//  out_ready  in   1   sink accepts head when out_valid & out_ready
//  drop_cnt   out  8   saturating count of discarded samples
//  busy       out  1   multiplier FSM not IDLE
// BEHAVIOUR
//  Reset (async, rst=1):
//   - FSM=IDLE; FIFO empty.
//   - out_valid=0, out_l=out_r=0, drop_cnt=0, busy=0.
//   - Reset mid-operation abandons the in-flight sample; no write occurs.
//  Capture:
//   - zero_d is registered on clk_en cycles only.
//   - A capture event is any clk_en cycle with zero_d=1, i.e. the first
//     clk_en after the accumulator updates its output.
//   - In IDLE, a capture latches left, right and vol (cycle t0).
//  FSM (all states advance every clk, not gated by clk_en):
//   - IDLE --capture--> MUL_L
//   - MUL_L: 8 cycles, t1..t8
//   - MUL_R: 8 cycles, t9..t16
//   - WR: 1 cycle, t17
//   - WR --> IDLE
//  Multiply:
//   - Shift-add, one vol bit per cycle, LSB first.
//   - 24-bit signed accumulator; partial = sample sign-extended << bit index.
//   - Result = acc >>> 7.
//   - Saturate: >32767 -> 0x7FFF; <-32768 -> 0x8000.
//  Write and output timing:
//   - FIFO is written at the end of t17.
//   - With the FIFO empty, out_valid=1 from t18; out_l/out_r are registered
//     head values.
//  Capture while busy:
//   - The sample is discarded and drop_cnt increments.
//   - The in-flight sample is unaffected.
//  FIFO:
//   - Pop when out_valid & out_ready.
//   - In WR with the FIFO full and no pop in the same cycle: the new sample is
//     discarded and drop_cnt increments.
//   - Full with a pop in the same cycle: the write succeeds; occupancy is
//     unchanged.
//   - Pointers wrap modulo DEPTH; occupancy counter is AW+1 bits.
//   - Empty with write and pop in the same cycle is impossible (out_valid=0),
//     so the write simply lands.
//  drop_cnt:
//   - Saturates at 0xFF. Cleared only by rst.
//   - Capture-while-busy and FIFO-full drop in the same cycle add 1 each;
//     the increment is at most +2, saturating.
//  vol changes after t0 take effect on the next sample only.
//  clk_en=0 holds zero_d; the FSM and FIFO keep running.
// TESTING
//  1) left=0x1000, right=0xF000, vol=0x80, one zero pulse
//     -> out_l=0x1000, out_r=0xF000, out_valid rises exactly 18 clk after
//        the capture cycle.
//  2) left=0x7000, right=0x8000, vol=0xFF
//     -> out_l=0x7FFF, out_r=0x8000 (both saturated); vol=0x40
//        -> 0x3800 / 0xC000.
//  3) vol=0x00, any inputs -> out_l=out_r=0x0000; vol=0x01 with left=0x0080
//     -> out_l=0x0001.
//  4) DEPTH=4, out_ready=0, 5 frames
//     -> 4 entries held in order, drop_cnt=1; then out_ready=1
//     -> 4 pops, out_valid falls after the 4th.
//  5) Full FIFO with out_ready=1 during WR
//     -> write accepted, drop_cnt unchanged, order preserved.
//     Second zero pulse 5 clk after capture -> drop_cnt+1, first sample intact.
//  6) Assert rst during MUL_R
//     -> busy=0, out_valid=0, drop_cnt=0 immediately.
//     Next frame after release -> correct result with 18-clk latency.

Source files
------------

// File: rtl/jt10_snd_out.sv
// jt10_snd_out: YM2610 stereo output stage. Frame capture, bit-serial Q1.7
// master volume with 16-bit saturation, and a small valid/ready FIFO.
`default_nettype none

module jt10_snd_out #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk_en,
  input  logic        zero,
  input  logic [15:0] left,
  input  logic [15:0] right,
  input  logic [7:0]  vol,
  output logic [15:0] out_l,
  output logic [15:0] out_r,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  drop_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL_L = 2'd1, MUL_R = 2'd2, WR = 2'd3} state_t;

  state_t             state;
  logic               zero_d;
  logic [2:0]         bit_idx;
  logic signed [23:0] acc;
  logic [15:0]        lat_l, lat_r, res_l, res_r;
  logic [7:0]         lat_vol;

  logic [31:0]        mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;

  logic               capture, pop, push, full, drop_busy, drop_full;
  logic [15:0]        cur;
  logic signed [23:0] partial, acc_next, scaled;
  logic [15:0]        sat;
  logic [8:0]         drop_sum;

  always_comb begin
    capture   = clk_en & zero_d;
    cur       = (state == MUL_R) ? lat_r : lat_l;
    partial   = lat_vol[bit_idx] ? ($signed({{8{cur[15]}}, cur}) <<< bit_idx) : 24'sd0;
    acc_next  = acc + partial;
    scaled    = acc_next >>> 7;
    if (scaled > 24'sd32767)
      sat = 16'h7FFF;
    else if (scaled < -24'sd32768)
      sat = 16'h8000;
    else
      sat = scaled[15:0];
    full      = (count == (AW+1)'(DEPTH));
    out_valid = (count != '0);
    pop       = out_valid & out_ready;
    push      = (state == WR) & (~full | pop);
    drop_full = (state == WR) & full & ~pop;
    drop_busy = capture & (state != IDLE);
    drop_sum  = {1'b0, drop_cnt} + {8'd0, drop_busy} + {8'd0, drop_full};
    busy      = (state != IDLE);
    out_l     = mem[rd_ptr][31:16];
    out_r     = mem[rd_ptr][15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      zero_d <= 1'b0;
    else if (clk_en)
      zero_d <= zero;
  end

  // One volume bit per clock, left channel first, then right.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
      acc     <= '0;
      lat_l   <= '0;
      lat_r   <= '0;
      lat_vol <= '0;
      res_l   <= '0;
      res_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (capture) begin
            lat_l   <= left;
            lat_r   <= right;
            lat_vol <= vol;
            acc     <= '0;
            bit_idx <= '0;
            state   <= MUL_L;
          end
        end
        MUL_L: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            res_l <= sat;
            acc   <= '0;
            state <= MUL_R;
          end else begin
            acc <= acc_next;
          end
        end
        MUL_R: begin
          bit_idx <= bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            res_r <= sat;
            acc   <= '0;
            state <= WR;
          end else begin
            acc <= acc_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {res_l, res_r};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      // Push and pop together leave occupancy unchanged.
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
      drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jt10_snd_out.sv
// Scoreboard bench for jt10_snd_out: expected samples are queued at capture
// and compared when the FIFO head is consumed.
`default_nettype none

module tb_jt10_snd_out;

  logic        clk = 1'b0, rst = 1'b1, clk_en = 1'b1, zero = 1'b0, out_ready = 1'b0;
  logic [15:0] left = '0, right = '0;
  logic [7:0]  vol = '0;
  logic [15:0] out_l, out_r;
  logic        out_valid, busy;
  logic [7:0]  drop_cnt;

  int passed = 0;
  int total  = 0;
  logic [31:0] sb [$];
  logic [31:0] exp_v;

  jt10_snd_out #(.DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero),
    .left(left), .right(right), .vol(vol),
    .out_l(out_l), .out_r(out_r), .out_valid(out_valid), .out_ready(out_ready),
    .drop_cnt(drop_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Returns at t0 (the capture cycle); expected result queued when keep=1.
  task automatic send(input logic [15:0] l, input logic [15:0] r, input logic [7:0] v,
                      input logic [15:0] el, input logic [15:0] er, input bit keep);
    left = l; right = r; vol = v; zero = 1'b1;
    tick;
    zero = 1'b0;
    if (keep) sb.push_back({el, er});
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      if (out_valid) ok = 1'b1;
      else tick;
    end
  endtask

  task automatic test_reset;
    #1;
    total++;
    if ({out_valid, busy, drop_cnt, out_l, out_r} !== 42'd0) begin
      $display("FAIL reset_state: got valid=%b busy=%b drop=%h l=%h r=%h, want all zero",
               out_valid, busy, drop_cnt, out_l, out_r);
    end else passed++;
    tick;
    rst = 1'b0;
    tick;
  endtask

  task automatic test_latency;
    bit early = 1'b0;
    send(16'h1000, 16'hF000, 8'h80, 16'h1000, 16'hF000, 1'b1);
    tick;
    total++;
    if (busy !== 1'b1) $display("FAIL busy_t1: got %b want 1", busy); else passed++;
    for (int i = 2; i <= 17; i++) begin
      tick;
      if (out_valid) early = 1'b1;
    end
    tick;
    total++;
    if (early || out_valid !== 1'b1)
      $display("FAIL latency18: early=%b valid_at_18=%b want early=0 valid=1", early, out_valid);
    else passed++;
    exp_v = sb.pop_front();
    total++;
    if ({out_l, out_r} !== exp_v) $display("FAIL unity_gain: got %h want %h", {out_l, out_r}, exp_v);
    else passed++;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL pop_empty: got valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_volume;
    logic [55:0] tbl [7];
    bit ok;
    tbl[0] = {16'h7000, 16'h8000, 8'hFF, 16'h7FFF};
    tbl[1] = {16'h7000, 16'h8000, 8'h40, 16'h3800};
    tbl[2] = {16'h1234, 16'hABCD, 8'h00, 16'h0000};
    tbl[3] = {16'h0080, 16'h0000, 8'h01, 16'h0001};
    tbl[4] = {16'hFFFF, 16'h0001, 8'hFF, 16'hFFFE};
    tbl[5] = {16'h8000, 16'h7FFF, 8'h80, 16'h8000};
    tbl[6] = {16'h8000, 16'hC000, 8'hFF, 16'h8000};
    for (int i = 0; i < 7; i++) begin
      logic [15:0] er;
      case (i)
        0: er = 16'h8000;
        1: er = 16'hC000;
        2: er = 16'h0000;
        3: er = 16'h0000;
        4: er = 16'h0001;
        5: er = 16'h7FFF;
        default: er = 16'h8080;
      endcase
      send(tbl[i][55:40], tbl[i][39:24], tbl[i][23:16], tbl[i][15:0], er, 1'b1);
      wait_valid(ok);
      exp_v = sb.pop_front();
      total++;
      if (!ok || {out_l, out_r} !== exp_v)
        $display("FAIL volume_%0d: valid=%b got %h want %h", i, ok, {out_l, out_r}, exp_v);
      else passed++;
      out_ready = 1'b1;
      tick;
      out_ready = 1'b0;
    end
  endtask

  task automatic fill4(input logic [15:0] base);
    for (int k = 0; k < 4; k++) begin
      logic [15:0] l;
      l = base + 16'(k * 16'h0111);
      send(l, ~l, 8'h80, l, ~l, 1'b1);
      repeat (19) tick;
    end
  endtask

  task automatic test_fifo_full;
    out_ready = 1'b0;
    fill4(16'h0001);
    send(16'h5555, 16'h6666, 8'h80, 16'h5555, 16'h6666, 1'b0);
    repeat (19) tick;
    total++;
    if (drop_cnt !== 8'd1 || out_valid !== 1'b1)
      $display("FAIL full_drop: got drop=%0d valid=%b want drop=1 valid=1", drop_cnt, out_valid);
    else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || {out_l, out_r} !== exp_v)
        $display("FAIL fifo_order_%0d: valid=%b got %h want %h", k, out_valid, {out_l, out_r}, exp_v);
      else passed++;
      tick;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL drained: got valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_full_pop;
    bit ok;
    fill4(16'h0A00);
    send(16'h0BBB, 16'h0CCC, 8'h80, 16'h0BBB, 16'h0CCC, 1'b1);
    repeat (17) tick;
    total++;
    if (busy !== 1'b1 || out_valid !== 1'b1)
      $display("FAIL wr_phase: got busy=%b valid=%b want 1 1", busy, out_valid);
    else passed++;
    out_ready = 1'b1;
    exp_v = sb.pop_front();
    total++;
    if ({out_l, out_r} !== exp_v) $display("FAIL pop_during_wr: got %h want %h", {out_l, out_r}, exp_v);
    else passed++;
    tick;
    out_ready = 1'b0;
    tick;
    total++;
    if (drop_cnt !== 8'd1) $display("FAIL full_pop_nodrop: got drop=%0d want 1", drop_cnt); else passed++;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_v = sb.pop_front();
      total++;
      if (out_valid !== 1'b1 || {out_l, out_r} !== exp_v)
        $display("FAIL full_pop_order_%0d: valid=%b got %h want %h", k, out_valid, {out_l, out_r}, exp_v);
      else passed++;
      tick;
    end
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL full_pop_drained: got valid=%b want 0", out_valid); else passed++;

    send(16'h2222, 16'h3333, 8'h80, 16'h2222, 16'h3333, 1'b1);
    repeat (4) tick;
    zero = 1'b1;
    tick;
    zero = 1'b0;
    tick;
    total++;
    if (drop_cnt !== 8'd2) $display("FAIL busy_drop: got drop=%0d want 2", drop_cnt); else passed++;
    wait_valid(ok);
    exp_v = sb.pop_front();
    total++;
    if (!ok || {out_l, out_r} !== exp_v)
      $display("FAIL inflight_intact: valid=%b got %h want %h", ok, {out_l, out_r}, exp_v);
    else passed++;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    total++;
    if (out_valid !== 1'b0) $display("FAIL single_entry: got valid=%b want 0", out_valid); else passed++;
  endtask

  task automatic test_clk_en;
    bit ok;
    clk_en = 1'b0;
    zero = 1'b1;
    left = 16'h0300; right = 16'h0400; vol = 8'h80;
    tick;
    clk_en = 1'b1;
    tick;
    zero = 1'b0;
    clk_en = 1'b0;
    repeat (3) tick;
    total++;
    if (busy !== 1'b0) $display("FAIL gated_capture: got busy=%b want 0", busy); else passed++;
    clk_en = 1'b1;
    sb.push_back({16'h0300, 16'h0400});
    tick;
    total++;
    if (busy !== 1'b1) $display("FAIL held_zero_d: got busy=%b want 1", busy); else passed++;
    wait_valid(ok);
    exp_v = sb.pop_front();
    total++;
    if (!ok || {out_l, out_r} !== exp_v)
      $display("FAIL clk_en_sample: valid=%b got %h want %h", ok, {out_l, out_r}, exp_v);
    else passed++;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit early = 1'b0;
    send(16'h4000, 16'h5000, 8'h80, 16'h4000, 16'h5000, 1'b1);
    repeat (10) tick;
    #3;
    rst = 1'b1;
    #1;
    sb.delete();
    total++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL async_reset: got busy=%b valid=%b drop=%0d want 0 0 0", busy, out_valid, drop_cnt);
    else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (12) tick;
    total++;
    if (out_valid !== 1'b0) $display("FAIL abandoned_write: got valid=%b want 0", out_valid); else passed++;
    send(16'h0100, 16'hFF00, 8'h80, 16'h0100, 16'hFF00, 1'b1);
    for (int i = 1; i <= 17; i++) begin
      tick;
      if (out_valid) early = 1'b1;
    end
    tick;
    total++;
    if (early || out_valid !== 1'b1)
      $display("FAIL post_reset_latency: early=%b valid=%b want 0 1", early, out_valid);
    else passed++;
    exp_v = sb.pop_front();
    total++;
    if ({out_l, out_r} !== exp_v) $display("FAIL post_reset_value: got %h want %h", {out_l, out_r}, exp_v);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_latency;
    test_volume;
    test_fifo_full;
    test_full_pop;
    test_clk_en;
    test_reset_mid;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
